// File: rtl/run_dump_pkg.sv
// Shared types and constants for the run/dump controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package run_dump_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        DUMP_REG = 3'd1,
        DUMP_MEM = 3'd2,
        END_REC  = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [1:0] KIND_PC  = 2'd0;
    localparam logic [1:0] KIND_REG = 2'd1;
    localparam logic [1:0] KIND_MEM = 2'd2;
    localparam logic [1:0] KIND_END = 2'd3;

endpackage

// File: rtl/dump_index_counter.sv
// Dump index counter: clear/advance with terminal-count flag, wraps to 0 on the last advance.
// Latency: index updates on the clock edge after i_advance; o_tc is combinational from the index.
// Backpressure: none of its own; the caller only advances on an accepted record.
// Ports: clk/rst (async, active-high), i_clear forces 0, i_advance steps the index,
//        i_last is the terminal value, o_idx the current index, o_tc = (o_idx == i_last).
module dump_index_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_advance,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_idx,
    output logic         o_tc
);

    logic [W-1:0] r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (i_clear || (i_advance && o_tc)) begin
            // Wrapping at the terminal count leaves the index at 0 for the next phase.
            r_idx <= '0;
        end else if (i_advance) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_idx = r_idx;
    assign o_tc  = (r_idx == i_last);

endmodule

// File: rtl/run_dump_controller.sv
// Run/termination and state-dump controller around a single-cycle machine: PC trace while running,
// then register, memory-window and end records after a halt instruction or cycle-limit timeout.
// Latency: records are combinational from state; one dump record at most per cycle.
// Backpressure: out_ready low stalls the machine (halt) during RUN and holds the current record otherwise.
// Ports: clk/reset (async, active-high); pc/inst from the machine; halt freezes the machine;
//        rf_raddr/rf_rdata and mem_raddr/mem_rdata are combinational debug reads;
//        out_valid/out_ready/out_kind/out_data form the record stream; done/timeout are sticky status.
module run_dump_controller
    import run_dump_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter int                 NUM_REGS   = 32,
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  MEM_BASE   = 'h4000,
    parameter int                 MEM_WORDS  = 4,
    parameter int                 MAX_CYCLES = 64,
    parameter logic [DATA_W-1:0]  HALT_INST  = '0,
    parameter bit                 TRACE_PC   = 1'b1,
    localparam int                RA_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] inst,
    output logic              halt,
    output logic [RA_W-1:0]   rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_kind,
    output logic [DATA_W-1:0] out_data,
    output logic              done,
    output logic              timeout
);

    localparam int CW     = $clog2(MAX_CYCLES + 1);
    localparam int IDX_MX = (NUM_REGS > MEM_WORDS) ? NUM_REGS : MEM_WORDS;
    localparam int IW     = (IDX_MX > 2) ? $clog2(IDX_MX) : 1;

    localparam logic [IW-1:0] LAST_REG = IW'(NUM_REGS - 1);
    localparam logic [IW-1:0] LAST_MEM = (MEM_WORDS > 0) ? IW'(MEM_WORDS - 1) : '0;
    localparam logic [CW-1:0] LAST_CYC = CW'(MAX_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cycle_cnt;
    logic                r_timeout;
    logic                r_done;

    logic [IW-1:0]       w_idx;
    logic                w_idx_tc;
    logic [IW-1:0]       w_idx_last;
    logic                w_idx_adv;

    logic                w_valid;
    logic [1:0]          w_kind;
    logic [DATA_W-1:0]   w_data;
    logic [RA_W-1:0]     w_rf_raddr;
    logic [ADDR_W-1:0]   w_mem_raddr;

    logic                w_run_stall;
    logic                w_advance;
    logic                w_accept;
    logic                w_is_halt;
    logic                w_at_limit;

    // While running, the only reason to hold the machine is an unaccepted trace record.
    assign w_run_stall = TRACE_PC & ~out_ready;
    assign w_advance   = (r_state == RUN) & ~w_run_stall;
    assign w_accept    = w_valid & out_ready;
    assign w_is_halt   = (inst == HALT_INST);
    assign w_at_limit  = (r_cycle_cnt == LAST_CYC);

    assign w_idx_last  = (r_state == DUMP_MEM) ? LAST_MEM : LAST_REG;
    assign w_idx_adv   = w_accept & ((r_state == DUMP_REG) | (r_state == DUMP_MEM));

    dump_index_counter #(
        .W (IW)
    ) u_idx (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (r_state == RUN),
        .i_advance (w_idx_adv),
        .i_last    (w_idx_last),
        .o_idx     (w_idx),
        .o_tc      (w_idx_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_kind      = KIND_PC;
        w_data      = '0;
        w_rf_raddr  = '0;
        w_mem_raddr = '0;
        case (r_state)
            RUN: begin
                w_valid = TRACE_PC;
                w_kind  = KIND_PC;
                w_data  = pc;
                // The halt instruction takes priority over the cycle limit.
                if (w_advance && (w_is_halt || w_at_limit)) begin
                    w_state_nxt = DUMP_REG;
                end
            end
            DUMP_REG: begin
                w_valid    = 1'b1;
                w_kind     = KIND_REG;
                w_rf_raddr = w_idx[RA_W-1:0];
                w_data     = rf_rdata;
                if (w_accept && w_idx_tc) begin
                    w_state_nxt = (MEM_WORDS == 0) ? END_REC : DUMP_MEM;
                end
            end
            DUMP_MEM: begin
                w_valid     = 1'b1;
                w_kind      = KIND_MEM;
                w_mem_raddr = MEM_BASE + ADDR_W'(w_idx);
                w_data      = mem_rdata;
                if (w_accept && w_idx_tc) begin
                    w_state_nxt = END_REC;
                end
            end
            END_REC: begin
                w_valid = 1'b1;
                w_kind  = KIND_END;
                w_data  = DATA_W'({r_timeout, r_cycle_cnt});
                if (w_accept) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_timeout   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // The terminating cycle is counted too, so the end record carries the full run length.
            if (w_advance) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
                if (w_at_limit && !w_is_halt) begin
                    r_timeout <= 1'b1;
                end
            end
            if ((r_state == END_REC) && w_accept) begin
                r_done <= 1'b1;
            end
        end
    end

    // Reset gates the combinational controls so the machine and sink see idle immediately.
    assign halt      = ~reset & ((r_state != RUN) | w_run_stall);
    assign out_valid = ~reset & w_valid;
    assign out_kind  = w_kind;
    assign out_data  = w_data;
    assign rf_raddr  = w_rf_raddr;
    assign mem_raddr = w_mem_raddr;
    assign done      = r_done;
    assign timeout   = r_timeout;

endmodule
